// File: rtl/bram_seq_ctrl.sv
// Load/play sequencer for a 256x16-class synchronous block RAM with separate
// write and read ports: fills a range from an input stream or streams it back.
module bram_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_play,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    input  logic              loop_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic              ram_wclke,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_rclke,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PLAY  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic              loop_r;
    logic [ADDR_W-1:0] cnt;

    logic              wr_vld_p0;
    logic              rd_vld_p0;
    logic              rd_vld_p1;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              fifo_wp;
    logic              fifo_rp;
    logic [1:0]        fifo_cnt;

    logic              start_ld;
    logic              start_pl;
    logic              abort;
    logic              wr_hs;
    logic              wr_last;
    logic              pop;
    logic              push;
    logic [2:0]        credit_sum;
    logic              rd_issue;
    logic              rd_last;
    logic              play_fin;
    logic [ADDR_W-1:0] iss_idx;
    logic [ADDR_W-1:0] iss_base;
    logic [ADDR_W-1:0] iss_len;
    logic              iss_loop;

    assign start_ld = (state == S_IDLE) && start_load;
    assign start_pl = (state == S_IDLE) && start_play && !start_load;

    // A load whose done is already showing cannot be aborted a second time.
    assign abort = stop && ((state == S_PLAY) || (state == S_FLUSH) ||
                            ((state == S_LOAD) && !done));

    assign wr_hs   = (state == S_LOAD) && in_valid && in_ready && !stop;
    assign wr_last = wr_hs && (cnt == len_r);

    assign pop  = out_valid && out_ready;
    // The RAM output holds its word until the FIFO has room for it.
    assign push = rd_vld_p1 && ((fifo_cnt != 2'd2) || pop);

    // Occupancy left after this cycle's pop plus the read not yet sampled by the RAM.
    assign credit_sum = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, rd_vld_p0};

    // The very first read leaves straight from IDLE to meet the play latency.
    always_comb begin
        iss_idx  = cnt;
        iss_base = base_r;
        iss_len  = len_r;
        iss_loop = loop_r;
        if (state == S_IDLE) begin
            iss_idx  = '0;
            iss_base = base;
            iss_len  = len;
            iss_loop = loop_en;
        end
    end

    assign rd_issue = start_pl ||
                      ((state == S_PLAY) && !stop && (credit_sum < 3'd2));
    assign rd_last  = (iss_idx == iss_len);

    assign play_fin = (state == S_FLUSH) && !stop && pop && (fifo_cnt == 2'd1) &&
                      !rd_vld_p1 && !rd_vld_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_load) begin
                    state_nxt = S_LOAD;
                end else if (start_play) begin
                    state_nxt = (rd_last && !iss_loop) ? S_FLUSH : S_PLAY;
                end
            end
            S_LOAD: begin
                if (stop || done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PLAY: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (rd_issue && rd_last && !iss_loop) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (abort || play_fin) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= '0;
            len_r  <= '0;
            loop_r <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= abort || play_fin || wr_last;
            if (start_ld || start_pl) begin
                base_r <= base;
                len_r  <= len;
                loop_r <= loop_en;
            end
            if (start_ld) begin
                cnt <= '0;
            end else if (wr_hs) begin
                cnt <= cnt + ADDR_W'(1);
            end else if (rd_issue) begin
                cnt <= rd_last ? '0 : iss_idx + ADDR_W'(1);
            end
        end
    end

    // Write stage p0: accepted word presented on the RAM write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            wr_vld_p0 <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
        end else begin
            if (start_ld) begin
                in_ready <= 1'b1;
            end else if ((state != S_LOAD) || stop || wr_last) begin
                in_ready <= 1'b0;
            end
            wr_vld_p0 <= wr_hs;
            if (wr_hs) begin
                ram_waddr <= base_r + cnt;
                ram_wdata <= in_data;
            end
        end
    end

    assign ram_we    = wr_vld_p0;
    assign ram_wclke = wr_vld_p0;

    // Read stage p0: address on the RAM read port; stage p1: word on ram_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p0 <= 1'b0;
            rd_vld_p1 <= 1'b0;
            ram_raddr <= '0;
        end else begin
            rd_vld_p0 <= rd_issue;
            if (rd_issue) begin
                ram_raddr <= iss_base + iss_idx;
            end
            if (abort) begin
                rd_vld_p1 <= 1'b0;
            end else if (rd_vld_p0) begin
                rd_vld_p1 <= 1'b1;
            end else if (push) begin
                rd_vld_p1 <= 1'b0;
            end
        end
    end

    assign ram_re    = rd_vld_p0;
    assign ram_rclke = rd_vld_p0;

    // Output stage: 2-entry FIFO, head drives the play stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            fifo_wp     <= 1'b0;
            fifo_rp     <= 1'b0;
            fifo_cnt    <= '0;
        end else if (abort) begin
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[fifo_wp] <= ram_rdata;
                fifo_wp           <= ~fifo_wp;
            end
            if (pop) begin
                fifo_rp <= ~fifo_rp;
            end
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    assign out_valid = (fifo_cnt != 2'd0);
    assign out_data  = fifo_mem[fifo_rp];

endmodule

// File: tb/tb_bram_seq_ctrl.sv
// Scoreboard bench for bram_seq_ctrl: directed load/play/loop/stop/reset
// sequences against a behavioural 256x16 RAM.
module tb_bram_seq_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_load, start_play, stop, loop_en;
    logic [ADDR_W-1:0] base, len;
    logic [DATA_W-1:0] in_data;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_ready;
    logic              busy, done;
    logic              ram_we, ram_wclke, ram_re, ram_rclke;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    bram_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_load(start_load), .start_play(start_play), .stop(stop),
        .base(base), .len(len), .loop_en(loop_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done),
        .ram_we(ram_we), .ram_wclke(ram_wclke), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_re(ram_re), .ram_rclke(ram_rclke), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    // RAM model: read data holds until the next sampled read
    logic [DATA_W-1:0] ram [256];
    always @(posedge clk) begin
        if (ram_we && ram_wclke) ram[ram_waddr] <= ram_wdata;
        if (ram_re && ram_rclke) ram_rdata <= ram[ram_raddr];
    end

    logic [15:0] exp_q[$];
    logic [23:0] wexp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_data = '0;
    logic [15:0] mon_e;
    logic [23:0] mon_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("out_extra", {16'h0, out_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", {16'h0, out_data}, {16'h0, mon_e});
                end
            end
            if (ram_we) begin
                chk("wclke", {31'h0, ram_wclke}, 32'h1);
                if (wexp_q.size() == 0) begin
                    fail_now("write_extra", {8'h0, ram_waddr, ram_wdata});
                end else begin
                    mon_w = wexp_q.pop_front();
                    chk("write", {8'h0, ram_waddr, ram_wdata}, {8'h0, mon_w});
                end
            end
            if (ram_re) chk("rclke", {31'h0, ram_rclke}, 32'h1);
            if (ram_we && ram_re) fail_now("we_and_re", {30'h0, ram_we, ram_re});
            if (prev_valid && !prev_ready && out_valid)
                chk("stall_stable", {16'h0, out_data}, {16'h0, prev_data});
            if (done) done_cnt++;
        end
        prev_valid = out_valid && rst_n;
        prev_ready = out_ready;
        prev_data  = out_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input logic bp, input int c);
        return bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, {31'h0, in_ready}, 32'h0);
        chk({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_out_data"}, {16'h0, out_data}, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_we"}, {30'h0, ram_we, ram_wclke}, 32'h0);
        chk({tag, "_waddr"}, {8'h0, ram_waddr, ram_wdata}, 32'h0);
        chk({tag, "_re"}, {30'h0, ram_re, ram_rclke}, 32'h0);
        chk({tag, "_raddr"}, {24'h0, ram_raddr}, 32'h0);
    endtask

    task automatic do_load(input logic [7:0] b, input logic [7:0] l, input logic [15:0] d0,
                           input logic both);
        int k;
        int c;
        start_load = 1'b1;
        start_play = both;
        base = b;
        len  = l;
        step();
        start_load = 1'b0;
        start_play = 1'b0;
        chk("ld_in_ready", {31'h0, in_ready}, 32'h1);
        chk("ld_busy", {31'h0, busy}, 32'h1);
        chk("ld_no_read", {31'h0, ram_re}, 32'h0);
        k = 0;
        c = 0;
        in_valid = 1'b1;
        while (k <= int'(l) && c < 600) begin
            in_data = d0 + 16'(k);
            if (in_ready) begin
                wexp_q.push_back({8'(int'(b) + k), in_data});
                k++;
            end
            step();
            c++;
        end
        in_valid = 1'b0;
        if (c >= 600) fail_now("ld_timeout", k);
        chk("ld_done", {31'h0, done}, 32'h1);
        chk("ld_in_ready_drop", {31'h0, in_ready}, 32'h0);
        step();
        chk("ld_done_pulse", {31'h0, done}, 32'h0);
        chk("ld_idle", {31'h0, busy}, 32'h0);
        chk("ld_all_writes", wexp_q.size(), 32'h0);
    endtask

    task automatic do_play(input logic [7:0] b, input logic [7:0] l, input logic lp,
                           input logic [15:0] d0, input int n, input logic bp, output int cyc);
        int c;
        for (int k = 0; k < n; k++) exp_q.push_back(d0 + 16'(k % (int'(l) + 1)));
        start_play = 1'b1;
        base = b;
        len = l;
        loop_en = lp;
        out_ready = rdy(bp, 0);
        step();
        start_play = 1'b0;
        c = 1;
        chk("pl_re", {31'h0, ram_re}, 32'h1);
        chk("pl_raddr", {24'h0, ram_raddr}, {24'h0, b});
        chk("pl_lat1", {31'h0, out_valid}, 32'h0);
        out_ready = rdy(bp, c);
        step();
        c++;
        chk("pl_lat2", {31'h0, out_valid}, 32'h0);
        out_ready = rdy(bp, c);
        step();
        c++;
        chk("pl_lat3", {31'h0, out_valid}, 32'h1);
        chk("pl_first", {16'h0, out_data}, {16'h0, d0});
        while (exp_q.size() != 0 && c < 3000) begin
            out_ready = rdy(bp, c);
            if (bp && c == 20) start_load = 1'b1;
            step();
            if (bp && c == 20) begin
                start_load = 1'b0;
                chk("busy_ignore_start", {31'h0, in_ready}, 32'h0);
            end
            c++;
        end
        if (exp_q.size() != 0) fail_now("pl_timeout", exp_q.size());
        cyc = c;
    endtask

    task automatic play_end();
        chk("pl_done", {31'h0, done}, 32'h1);
        chk("pl_idle", {31'h0, busy}, 32'h0);
        chk("pl_valid_low", {31'h0, out_valid}, 32'h0);
        step();
        chk("pl_done_pulse", {31'h0, done}, 32'h0);
    endtask

    int cyc;
    int dc;

    initial begin
        rst_n = 1'b1;
        start_load = 1'b0;
        start_play = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        base = '0;
        len = '0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Load with both starts high: LOAD must win
        do_load(8'h10, 8'd3, 16'hA001, 1'b1);

        // Full-throughput playback of the same range
        do_play(8'h10, 8'd3, 1'b0, 16'hA001, 4, 1'b0, cyc);
        chk("pl_throughput", cyc, 32'd7);
        play_end();

        // Whole-RAM load, then playback under 1,0,0,1 backpressure
        do_load(8'h00, 8'hFF, 16'h1000, 1'b0);
        do_play(8'h00, 8'hFF, 1'b0, 16'h1000, 256, 1'b1, cyc);
        play_end();

        // Address wrap, looped playback, then stop
        do_load(8'hFE, 8'd3, 16'hB001, 1'b0);
        chk("wrap_fe", {16'h0, ram[8'hFE]}, 32'hB001);
        chk("wrap_ff", {16'h0, ram[8'hFF]}, 32'hB002);
        chk("wrap_00", {16'h0, ram[8'h00]}, 32'hB003);
        chk("wrap_01", {16'h0, ram[8'h01]}, 32'hB004);
        do_play(8'hFE, 8'd3, 1'b1, 16'hB001, 14, 1'b0, cyc);
        chk("loop_throughput", cyc, 32'd17);
        out_ready = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_valid", {31'h0, out_valid}, 32'h0);
        chk("stop_done", {31'h0, done}, 32'h1);
        chk("stop_idle", {31'h0, busy}, 32'h0);
        step();
        chk("stop_done_pulse", {31'h0, done}, 32'h0);
        loop_en = 1'b0;

        // Reset with a read in flight
        out_ready = 1'b1;
        start_play = 1'b1;
        base = 8'h10;
        len = 8'd3;
        step();
        start_play = 1'b0;
        chk("rst_pre_re", {31'h0, ram_re}, 32'h1);
        dc = done_cnt;
        rst_n = 1'b0;
        #1 chk_zero("midrst");
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rst_no_done", done_cnt, dc);
        chk("rst_idle", {31'h0, busy}, 32'h0);
        do_play(8'h10, 8'd3, 1'b0, 16'h1010, 4, 1'b0, cyc);
        chk("rst_replay_throughput", cyc, 32'd7);
        play_end();

        step();
        chk("done_total", done_cnt, 32'd7);
        chk("exp_left", exp_q.size(), 32'h0);
        chk("wexp_left", wexp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
